// File: rtl/prog_inst_mem_pkg.sv
// Shared types and defaults for the runtime-loadable instruction memory.
package inst_mem_pkg;

  localparam int DATA_W_DEF = 13;
  localparam int ADDR_W_DEF = 5;

  localparam logic [DATA_W_DEF-1:0] NOP = '0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

endpackage

// File: rtl/prog_inst_mem_if.sv
// Fetch and program-load bus between the PC/boot host (master) and the memory (slave).
interface prog_inst_mem_if
  import inst_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_instr;
  logic              fetch_oob;

  logic              load_start;
  logic              load_valid;
  logic              load_last;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_done;
  logic              busy;
  logic [ADDR_W:0]   prog_len;

  modport master (
    output fetch_req, fetch_addr, load_start, load_valid, load_last, load_data,
    input  fetch_valid, fetch_instr, fetch_oob, load_ready, load_done, busy, prog_len
  );

  modport slave (
    input  fetch_req, fetch_addr, load_start, load_valid, load_last, load_data,
    output fetch_valid, fetch_instr, fetch_oob, load_ready, load_done, busy, prog_len
  );

endinterface

// File: rtl/prog_inst_mem_array.sv
// Instruction storage: one synchronous write port, one registered read port, zero at power-up.
module inst_mem_array
  import inst_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Read register only updates on a served fetch so the output holds between fetches.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/prog_inst_mem.sv
// Runtime-loadable instruction memory: load FSM, program-length tracking and registered fetch port.
//   state   | meaning
//   ST_IDLE | fetches served, waiting for load_start
//   ST_LOAD | accepting program words, fetches dropped
module prog_inst_mem
  import inst_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  prog_inst_mem_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic              load_done_q, load_done_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              fetch_oob_q, fetch_oob_d;

  logic              mem_we, mem_re;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    prog_len_d    = prog_len_q;
    load_done_d   = 1'b0;
    fetch_valid_d = 1'b0;
    fetch_oob_d   = fetch_oob_q;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.fetch_req) begin
          fetch_valid_d = 1'b1;
          fetch_oob_d   = ({1'b0, bus.fetch_addr} >= prog_len_q);
          mem_re        = 1'b1;
        end
        if (bus.load_start) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
        end
      end
      ST_LOAD: begin
        if (bus.load_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          // The top word always ends the load, whether or not the host flagged it.
          if (bus.load_last || (wr_ptr_q == '1)) begin
            state_d     = ST_IDLE;
            prog_len_d  = {1'b0, wr_ptr_q} + (ADDR_W+1)'(1);
            load_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      prog_len_q    <= (ADDR_W+1)'(DEPTH);
      load_done_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_oob_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      prog_len_q    <= prog_len_d;
      load_done_q   <= load_done_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_oob_q   <= fetch_oob_d;
    end
  end

  inst_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we && !rst),
    .waddr (wr_ptr_q),
    .wdata (bus.load_data),
    .re    (mem_re),
    .raddr (bus.fetch_addr),
    .rdata (rd_data)
  );

  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_oob   = fetch_oob_q;
  assign bus.fetch_instr = fetch_oob_q ? DATA_W'(NOP) : rd_data;
  assign bus.load_ready  = (state_q == ST_LOAD);
  assign bus.busy        = (state_q == ST_LOAD);
  assign bus.load_done   = load_done_q;
  assign bus.prog_len    = prog_len_q;

endmodule

// File: tb/tb_prog_inst_mem.sv
// Bench for prog_inst_mem: directed table and sequences plus random traffic against a word-level model.
module tb_prog_inst_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_inst_mem_if #(.DATA_W(13), .ADDR_W(5)) bus ();

  prog_inst_mem #(.DATA_W(13), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: program image, loaded length, and an in-progress load counter.
  logic [12:0] m_mem [32];
  int          m_len;
  bit          m_loading;
  int          m_count;
  bit          e_valid, e_oob, e_done;
  logic [12:0] e_instr;

  typedef struct {
    int req, addr, start, lvalid, last, data;
    int e_valid, e_instr, e_oob, e_busy, e_done, e_len;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit rq, input int ad, input bit st,
                            input bit lv, input bit ll, input logic [12:0] d);
    e_valid = 1'b0;
    e_done  = 1'b0;
    if (r) begin
      m_loading = 1'b0;
      m_count   = 0;
      m_len     = 32;
      e_instr   = '0;
      e_oob     = 1'b0;
    end else if (!m_loading) begin
      if (rq) begin
        e_valid = 1'b1;
        e_oob   = (ad >= m_len);
        e_instr = e_oob ? 13'h0 : m_mem[ad];
      end
      if (st) begin
        m_loading = 1'b1;
        m_count   = 0;
      end
    end else if (lv) begin
      m_mem[m_count] = d;
      m_count++;
      if (ll || m_count == 32) begin
        m_loading = 1'b0;
        m_len     = m_count;
        e_done    = 1'b1;
      end
    end
  endtask

  task automatic cycle(input bit rq, input int ad, input bit st, input bit lv,
                       input bit ll, input logic [12:0] d, input bit r = 1'b0);
    rst            = r;
    bus.fetch_req  = rq;
    bus.fetch_addr = 5'(ad);
    bus.load_start = st;
    bus.load_valid = lv;
    bus.load_last  = ll;
    bus.load_data  = d;
    model_step(r, rq, ad, st, lv, ll, d);
    @(posedge clk);
    #1;
    chk("fetch_valid", 32'(bus.fetch_valid), 32'(e_valid));
    chk("fetch_instr", 32'(bus.fetch_instr), 32'(e_instr));
    if (e_valid) chk("fetch_oob", 32'(bus.fetch_oob), 32'(e_oob));
    chk("busy", 32'(bus.busy), 32'(m_loading));
    chk("load_ready", 32'(bus.load_ready), 32'(m_loading));
    chk("load_done", 32'(bus.load_done), 32'(e_done));
    chk("prog_len", 32'(bus.prog_len), 32'(m_len));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, '0);
  endtask

  logic [12:0] w [32];
  int          done_cnt;

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_len = 32; m_loading = 0; m_count = 0; e_instr = '0; e_oob = 0;
    bus.fetch_req = 0; bus.fetch_addr = '0; bus.load_start = 0;
    bus.load_valid = 0; bus.load_last = 0; bus.load_data = '0;

    cycle(0, 0, 0, 0, 0, '0, 1'b1);
    cycle(0, 0, 0, 0, 0, '0, 1'b1);
    chk("rst_prog_len", 32'(bus.prog_len), 32'd32);
    chk("rst_instr", 32'(bus.fetch_instr), 32'd0);

    // Power-up contents are zero and the whole array counts as program.
    for (int a = 0; a < 32; a++) begin
      cycle(1, a, 0, 0, 0, '0);
      chk("boot_valid", 32'(bus.fetch_valid), 32'd1);
      chk("boot_instr", 32'(bus.fetch_instr), 32'd0);
      chk("boot_oob", 32'(bus.fetch_oob), 32'd0);
    end

    // Eight-word load 0x1c00..0x1c77 then fetches inside and past the program.
    tbl[0] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32};
    for (int i = 0; i < 8; i++)
      tbl[1+i] = '{0, 0, 0, 1, int'(i == 7), 'h1c00 + 'h11*i,
                   0, 0, 0, int'(i != 7), int'(i == 7), (i == 7) ? 8 : 32};
    tbl[9]  = '{1, 3, 0, 0, 0, 0, 1, 'h1c33, 0, 0, 0, 8};
    tbl[10] = '{1, 8, 0, 0, 0, 0, 1, 'h0000, 1, 0, 0, 8};
    tbl[11] = '{1, 7, 0, 0, 0, 0, 1, 'h1c77, 0, 0, 0, 8};
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].req[0], tbl[i].addr, tbl[i].start[0], tbl[i].lvalid[0],
            tbl[i].last[0], 13'(tbl[i].data));
      chk("tbl_valid", 32'(bus.fetch_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid != 0) begin
        chk("tbl_instr", 32'(bus.fetch_instr), 32'(tbl[i].e_instr));
        chk("tbl_oob", 32'(bus.fetch_oob), 32'(tbl[i].e_oob));
      end
      chk("tbl_busy", 32'(bus.busy), 32'(tbl[i].e_busy));
      chk("tbl_done", 32'(bus.load_done), 32'(tbl[i].e_done));
      chk("tbl_len", 32'(bus.prog_len), 32'(tbl[i].e_len));
    end

    // Full-depth load with no load_last: exits on its own after word 31.
    for (int i = 0; i < 32; i++) w[i] = 13'($urandom);
    cycle(0, 0, 1, 0, 0, '0);
    done_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(0, 0, 0, 1, 0, w[i]);
      done_cnt += int'(bus.load_done);
    end
    chk("full_done_cnt", 32'(done_cnt), 32'd1);
    chk("full_len", 32'(bus.prog_len), 32'd32);
    cycle(1, 31, 0, 0, 0, '0);
    chk("full_w31", 32'(bus.fetch_instr), 32'(w[31]));

    // fetch_req held through a 4-word load; start cycle still serves old data.
    for (int i = 0; i < 4; i++) w[i] = 13'($urandom);
    cycle(1, 1, 1, 0, 0, '0);
    chk("hold_old", 32'(bus.fetch_instr), 32'(m_mem[1]));
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 1, int'(i == 3) != 0, w[i]);
      chk("hold_drop", 32'(bus.fetch_valid), 32'd0);
    end
    chk("hold_done", 32'(bus.load_done), 32'd1);
    cycle(1, 0, 0, 0, 0, '0);
    chk("hold_new", 32'(bus.fetch_instr), 32'(w[0]));
    chk("hold_len", 32'(bus.prog_len), 32'd4);

    // Reset after three of six words.
    for (int i = 0; i < 6; i++) w[i] = 13'($urandom);
    cycle(0, 0, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, w[i]);
    cycle(0, 0, 0, 1, 0, w[3], 1'b1);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_len", 32'(bus.prog_len), 32'd32);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 0, '0);
      done_cnt += int'(bus.load_done);
    end
    chk("rstmid_no_done", 32'(done_cnt), 32'd0);
    cycle(1, 2, 0, 0, 0, '0);
    chk("rstmid_w2", 32'(bus.fetch_instr), 32'(w[2]));
    cycle(1, 3, 0, 0, 0, '0);
    chk("rstmid_w3_old", 32'(bus.fetch_instr), 32'(m_mem[3]));

    // load_valid in IDLE writes nothing; load_start in LOAD does not restart.
    cycle(0, 0, 0, 1, 1, 13'h1abc);
    cycle(0, 0, 0, 1, 0, 13'h0def);
    cycle(0, 0, 1, 0, 0, '0);
    cycle(0, 0, 0, 1, 0, 13'h0111);
    cycle(0, 0, 1, 0, 0, '0);
    cycle(0, 0, 1, 1, 1, 13'h0222);
    chk("nores_len", 32'(bus.prog_len), 32'd2);
    cycle(1, 1, 0, 0, 0, '0);
    chk("nores_w1", 32'(bus.fetch_instr), 32'h0222);
    cycle(1, 2, 0, 0, 0, '0);
    chk("nores_oob", 32'(bus.fetch_oob), 32'd1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 9) == 0), 13'($urandom),
            ($urandom_range(0, 499) == 0));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_inst_mem.md
# prog_inst_mem

Parametrised, runtime-loadable instruction memory for the instruction unit. Replaces the fixed 32×13 ROM-style store. Adds:
- a streaming program-load port;
- a registered fetch port with a valid handshake;
- program-length tracking, so fetches past the loaded program return a NOP (all zeros).

It sits between the program counter and the decoder. The load port is driven by the test/boot host.

## Interface
- DATA_W, 13, instruction width in bits
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_req  in  1  fetch request, ignored while busy
- fetch_addr  in  ADDR_W  fetch address
- fetch_valid  out  1  fetch_instr valid this cycle
- fetch_instr  out  DATA_W  fetched instruction
- fetch_oob  out  1  qualifies fetch_valid; addressed word lies at or beyond prog_len
- load_start  in  1  begin program load (pulse)
- load_valid  in  1  load_data valid
- load_last  in  1  with load_valid: final word of program
- load_data  in  DATA_W  program word
- load_ready  out  1  block accepts load words
- load_done  out  1  one-cycle pulse, load complete
- busy  out  1  load in progress; fetches not served
- prog_len  out  ADDR_W+1  number of valid program words, range 0..DEPTH

## Operation
- State machine has two states.
  - IDLE: fetches served. load_start moves to LOAD and clears wr_ptr.
  - LOAD: busy=1 and load_ready=1. Each cycle with load_valid & load_ready:
    - writes mem[wr_ptr] = load_data;
    - increments wr_ptr.
- LOAD exits to IDLE on either condition:
  - an accepted word with load_last=1;
  - an accepted word at wr_ptr == DEPTH-1, regardless of load_last.
- On exit:
  - prog_len = wr_ptr+1 (count of words written);
  - load_done pulses in the first IDLE cycle.
- Words above the new prog_len keep their old contents but are reported out-of-bounds.
- Fetch, in IDLE only: fetch_req samples fetch_addr. The next cycle gives:
  - fetch_valid=1;
  - fetch_instr = (fetch_addr < prog_len) ? mem[fetch_addr] : 0;
  - fetch_oob = (fetch_addr >= prog_len).
- fetch_req in LOAD is dropped, not queued: fetch_valid=0 next cycle.
- load_start while in LOAD is ignored.
- load_valid while in IDLE is ignored; no write occurs.
- Comparison fetch_addr < prog_len is unsigned, at ADDR_W+1 bits.
- Memory contents are zero at time 0. Reset does not clear contents.

## Timing
- Reset values:
  - state IDLE, wr_ptr 0;
  - fetch_valid 0, fetch_instr 0, fetch_oob 0;
  - load_ready 0, load_done 0, busy 0;
  - prog_len DEPTH.
- Fetch latency is 1 cycle. Throughput is one fetch per cycle, back-to-back.
- Load throughput is one word per cycle. load_ready and busy are driven from the registered state only.
- LOAD lasts N cycles for an N-word stream with no bubbles. busy deasserts and load_done asserts in the same cycle.
- Fetch in the load_done cycle is served and sees the new contents and prog_len.
- fetch_req in the same cycle as load_start (IDLE): fetch served from old contents; LOAD entered next cycle.
- Reset mid-load forces the following on the next edge:
  - IDLE, wr_ptr 0;
  - prog_len DEPTH;
  - no load_done.
  Words already written remain.
- fetch_valid, fetch_oob and fetch_instr are registered outputs. fetch_instr holds its last value when fetch_valid=0.

## Structure
- Package inst_mem_pkg holds:
  - state enum (ST_IDLE, ST_LOAD);
  - default DATA_W/ADDR_W localparams;
  - NOP constant (all zeros).
- Sub-module inst_mem_array holds the storage:
  - DATA_W × DEPTH;
  - one synchronous write port;
  - one synchronous read port;
  - zero initialisation.
- The top level owns the FSM, wr_ptr, prog_len, the OOB compare and output registers.

## Test plan
- After reset, fetch addr 0..31 back-to-back -> fetch_valid each cycle after req, instr 0, fetch_oob 0 (prog_len=32).
- Load 8 words 0x1c00..0x1c77, load_last on 8th -> load_done pulses once, prog_len=8. Then:
  - fetch 3 -> 0x1c33, oob 0;
  - fetch 8 -> 0x0000, oob 1.
- Load 32 words with load_last never asserted -> auto-exit after word 31, prog_len=32, fetch 31 returns word 31.
- fetch_req held high throughout a 4-word load -> fetch_valid 0 during LOAD; first fetch after load_done returns new data.
- Assert rst after 3 of 6 load words -> busy 0, load_done never pulses, prog_len=32, fetch 2 returns the 3rd loaded word.
- load_start pulsed during LOAD, and load_valid pulsed in IDLE -> no restart, no writes, contents unchanged.
